// File: rtl/gfifo_arb_pkg.sv
// Shared types and helpers for the GFIFO request arbiter.
// Optional timestamp header beat is enabled by defining GFIFO_ARB_TS_EN.
package gfifo_arb_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_DW   = 512;
  localparam int unsigned DEF_CBW  = 20;
  localparam int unsigned DEF_LW   = 12;
  localparam int unsigned MAX_REQ  = 16;

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} arbState_t;

  // Returns {found, index}: first set bit of req after ptr, wrapping within n.
  function automatic logic [4:0] rrFindFirst(input logic [MAX_REQ-1:0] req,
                                             input logic [3:0] ptr,
                                             input int unsigned n);
    logic [4:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k <= n && !res[4] && req[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/gfifo_rr_pick.sv
// Combinational round-robin picker: first requester after rrPtr, with wrap.
module gfifo_rr_pick
  import gfifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rrPtr,
  output logic [IW-1:0]   winner,
  output logic            found
);

  logic [MAX_REQ-1:0] reqExt;
  logic [4:0]         pick;

  always_comb begin
    reqExt = '0;
    reqExt[NREQ-1:0] = req;
    pick   = rrFindFirst(reqExt, 4'(rrPtr), NREQ);
    winner = IW'(pick[3:0]);
    found  = pick[4];
  end

endmodule

// File: rtl/gfifo_req_arbiter.sv
// Round-robin arbiter sharing the GFIFO write port, one whole message per grant.
// Define GFIFO_ARB_TS_EN to prepend a sim_time header beat to every message.
module gfifo_req_arbiter
  import gfifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned CBW  = DEF_CBW,
  parameter int unsigned LW   = DEF_LW
) (
  input  logic                     fclk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CBW-1:0]      req_cbid,
  input  logic [NREQ*LW-1:0]       req_len,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ-1:0]          req_dvalid,
  output logic [NREQ-1:0]          req_dready,
  output logic [NREQ-1:0]          req_done,
  input  logic                     gf_full,
  output logic                     gf_req,
  output logic [CBW-1:0]           gf_cbid,
  output logic [LW-1:0]            gf_len,
  output logic [DW-1:0]            gf_data,
  output logic                     gf_lock,
  output logic                     gf_busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  input  logic [63:0]              sim_time
);

  localparam int unsigned IW = $clog2(NREQ);

  arbState_t       state;
  logic [IW-1:0]   rrPtr;
  logic [IW-1:0]   winner;
  logic            found;
  logic [LW-1:0]   beatsLeft;
  logic            outFree;
  logic            grantReady;
  logic [NREQ-1:0] grantOneHot;
  logic [LW-1:0]   winLen;

`ifdef GFIFO_ARB_TS_EN
  logic [63:0]     tsQ;
`else
  logic            unusedSimTime;
  assign unusedSimTime = ^sim_time;
`endif

  gfifo_rr_pick #(.NREQ(NREQ), .IW(IW)) uPick (
    .req    (req_valid),
    .rrPtr  (rrPtr),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    winLen      = req_len[int'(winner)*LW +: LW];
    grantOneHot = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
    outFree     = !gf_req || !gf_full;
    grantReady  = (state == DATA) && outFree && (beatsLeft != '0);
    req_dready  = grantReady ? grantOneHot : '0;
    gf_busy     = (|req_valid) || (state != IDLE);
  end

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rrPtr     <= IW'(NREQ - 1);
      grant_id  <= '0;
      beatsLeft <= '0;
      gf_req    <= 1'b0;
      gf_cbid   <= '0;
      gf_len    <= '0;
      gf_data   <= '0;
      gf_lock   <= 1'b0;
      req_done  <= '0;
`ifdef GFIFO_ARB_TS_EN
      tsQ       <= '0;
`endif
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= winner;
            rrPtr     <= winner;
            gf_cbid   <= req_cbid[int'(winner)*CBW +: CBW];
            beatsLeft <= winLen;
            gf_lock   <= 1'b1;
`ifdef GFIFO_ARB_TS_EN
            gf_len    <= winLen + LW'(1);
            tsQ       <= sim_time;
            state     <= HDR;
`else
            gf_len    <= winLen;
            state     <= DATA;
`endif
          end
        end
        HDR: begin
          if (outFree) begin
`ifdef GFIFO_ARB_TS_EN
            gf_data <= DW'(tsQ);
`endif
            gf_req  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          // Load and drain share the single stage; a load wins over clearing gf_req.
          if (grantReady && req_dvalid[grant_id]) begin
            gf_data   <= req_data[int'(grant_id)*DW +: DW];
            gf_req    <= 1'b1;
            beatsLeft <= beatsLeft - LW'(1);
          end else if (gf_req && !gf_full) begin
            gf_req <= 1'b0;
          end
          if (beatsLeft == '0 && outFree) begin
            req_done <= grantOneHot;
            state    <= DONE;
          end
        end
        DONE: begin
          gf_lock <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfifo_req_arbiter.sv
// Scoreboard bench for gfifo_req_arbiter; header-beat expectations follow GFIFO_ARB_TS_EN.
module tb_gfifo_req_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int CBW  = 20;
  localparam int LW   = 12;
`ifdef GFIFO_ARB_TS_EN
  localparam int TS = 1;
`else
  localparam int TS = 0;
`endif

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [CBW-1:0] cbid;
    logic [LW-1:0]  len;
  } beat_t;

  logic                fclk = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid, req_dvalid, req_dready, req_done;
  logic [NREQ*CBW-1:0] req_cbid;
  logic [NREQ*LW-1:0]  req_len;
  logic [NREQ*DW-1:0]  req_data;
  logic                gf_full, gf_req, gf_lock, gf_busy;
  logic [CBW-1:0]      gf_cbid;
  logic [LW-1:0]       gf_len;
  logic [DW-1:0]       gf_data;
  logic [1:0]          grant_id;
  logic [63:0]         sim_time;

  gfifo_req_arbiter #(.NREQ(NREQ), .DW(DW), .CBW(CBW), .LW(LW)) dut (
    .fclk(fclk), .reset_n(reset_n),
    .req_valid(req_valid), .req_cbid(req_cbid), .req_len(req_len),
    .req_data(req_data), .req_dvalid(req_dvalid), .req_dready(req_dready),
    .req_done(req_done), .gf_full(gf_full), .gf_req(gf_req),
    .gf_cbid(gf_cbid), .gf_len(gf_len), .gf_data(gf_data),
    .gf_lock(gf_lock), .gf_busy(gf_busy), .grant_id(grant_id),
    .sim_time(sim_time)
  );

  always #5 fclk = ~fclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  beat_t expQ[$], obsQ[$];
  int doneIdx[$], doneCyc[$];
  logic [CBW-1:0] cbidOf[NREQ];
  logic [LW-1:0]  lenOf[NREQ];
  int beatCnt[NREQ];
  bit holdReq = 0;
  int beatsSeen, reqCycles, stallCycles, lockCycles, lastBeatCyc;
  int holdViol, dreadyWhileFull, dreadyNonGrant;
  bit stalledPrev = 0;
  beat_t prevBeat;
`ifdef GFIFO_ARB_TS_EN
  int benchPtr = NREQ - 1;
  bit lockSeen = 0;
`endif

  function automatic logic [DW-1:0] beatData(input int r, input int k);
    return {8'(r), 16'(k), 8'h5A, 32'(k) ^ 32'hC3A5_0F1E ^ 32'(r * 1234567)};
  endfunction

  function automatic logic [LW-1:0] expLen(input logic [LW-1:0] l);
    return l + LW'(TS);
  endfunction

  // Bus monitor: beats leave at the next rising edge when gf_req && !gf_full.
  always @(negedge fclk) begin
    if (reset_n) begin
      if (gf_req && !gf_full) begin
        obsQ.push_back({gf_data, gf_cbid, gf_len});
        beatsSeen++;
        lastBeatCyc = cyc;
      end
      if (gf_req) reqCycles++;
      if (gf_req && gf_full) stallCycles++;
      if (gf_lock) lockCycles++;
      if (stalledPrev && !(gf_req && {gf_data, gf_cbid, gf_len} == prevBeat)) holdViol++;
      stalledPrev = gf_req && gf_full;
      prevBeat = {gf_data, gf_cbid, gf_len};
      if (gf_req && gf_full && req_dready != '0) dreadyWhileFull++;
      if ((req_dready & ~(4'b0001 << grant_id)) != '0) dreadyNonGrant++;
      for (int r = 0; r < NREQ; r++)
        if (req_done[r]) begin
          doneIdx.push_back(r);
          doneCyc.push_back(cyc);
        end
    end else begin
      stalledPrev = 0;
    end
  end

  task automatic setMsg(input int r, input logic [CBW-1:0] cbid, input logic [LW-1:0] len);
    cbidOf[r] = cbid;
    lenOf[r] = len;
    beatCnt[r] = 0;
    req_cbid[r*CBW +: CBW] = cbid;
    req_len[r*LW +: LW] = len;
    req_data[r*DW +: DW] = beatData(r, 0);
  endtask

  // One requester-model cycle: record accepted beats, then drive the next data.
  task automatic tick();
    logic [NREQ-1:0] doneNow;
    @(negedge fclk);
    for (int r = 0; r < NREQ; r++)
      if (req_valid[r] && req_dvalid[r] && req_dready[r]) begin
        expQ.push_back({beatData(r, beatCnt[r]), cbidOf[r], expLen(lenOf[r])});
        beatCnt[r]++;
      end
`ifdef GFIFO_ARB_TS_EN
    if (gf_lock && !lockSeen) begin
      int w;
      w = benchPtr;
      for (int k = 1; k <= NREQ; k++)
        if (req_valid[(benchPtr + k) % NREQ]) begin
          w = (benchPtr + k) % NREQ;
          break;
        end
      benchPtr = w;
      expQ.push_back({DW'(sim_time), cbidOf[w], expLen(lenOf[w])});
    end
    lockSeen = gf_lock;
`endif
    doneNow = req_done;
    @(posedge fclk);
    cyc++;
    #1;
    for (int r = 0; r < NREQ; r++) begin
      if (!holdReq && doneNow[r]) begin
        req_valid[r] = 1'b0;
        req_dvalid[r] = 1'b0;
      end
      req_data[r*DW +: DW] = beatData(r, beatCnt[r]);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    req_valid = '0;
    req_dvalid = '0;
    gf_full = 1'b0;
    repeat (2) @(posedge fclk);
    #1 reset_n = 1'b1;
    expQ.delete(); obsQ.delete(); doneIdx.delete(); doneCyc.delete();
`ifdef GFIFO_ARB_TS_EN
    benchPtr = NREQ - 1;
    lockSeen = 0;
`endif
  endtask

  task automatic test_reset();
    logic [108:0] outs;
    reset_n = 1'b1;
    req_valid = '0; req_dvalid = '0; gf_full = 1'b0;
    req_cbid = '0; req_len = '0; req_data = '0;
    sim_time = 64'h1000;
    @(posedge fclk); #1 reset_n = 1'b0;
    #2;
    outs = {gf_req, gf_lock, gf_busy, req_done, req_dready, grant_id, gf_cbid, gf_len, gf_data};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", outs); end
    @(posedge fclk); #1 reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({gf_busy, gf_lock, gf_req} !== 3'b000) begin
      failures++; $display("FAIL idle_after_reset got=%b want=000", {gf_busy, gf_lock, gf_req});
    end
  endtask

  task automatic test_single();
    lockCycles = 0; dreadyNonGrant = 0; holdReq = 0;
    doneIdx.delete(); doneCyc.delete();
    setMsg(0, 20'h12345, 3);
    req_valid[0] = 1'b1; req_dvalid[0] = 1'b1;
    for (int i = 0; i < 30 && doneIdx.size() == 0; i++) tick();
    repeat (3) tick();
    checks++;
    if (doneIdx.size() != 1 || doneIdx[0] != 0) begin
      failures++; $display("FAIL single_done count=%0d want=1 on req 0", doneIdx.size());
    end else begin
      checks++;
      if (doneCyc[0] - lastBeatCyc != 1) begin
        failures++; $display("FAIL single_done_latency got=%0d want=1", doneCyc[0] - lastBeatCyc);
      end
    end
    checks++;
    if (lockCycles != 5 + TS) begin
      failures++; $display("FAIL single_lock_cycles got=%0d want=%0d", lockCycles, 5 + TS);
    end
    checks++;
    if ({gf_lock, gf_busy} !== 2'b00 || dreadyNonGrant != 0) begin
      failures++; $display("FAIL single_end lock_busy=%b nongrant=%0d want=00/0", {gf_lock, gf_busy}, dreadyNonGrant);
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      beat_t o, e;
      o = obsQ.pop_front(); e = expQ.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL single_beat got=%h want=%h", o, e); end
    end
    checks++;
    if (obsQ.size() != 0 || expQ.size() != 0) begin
      failures++; $display("FAIL single_leftover obs=%0d exp=%0d want=0/0", obsQ.size(), expQ.size());
    end
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    int badGap;
    doReset();
    for (int r = 0; r < NREQ; r++) setMsg(r, 20'hA0000 + 20'(r), 1);
    holdReq = 1;
    req_valid = '1; req_dvalid = '1;
    for (int i = 0; i < 80 && doneIdx.size() < 5; i++) tick();
    req_valid = '0; req_dvalid = '0;
    holdReq = 0;
    repeat (3) tick();
    checks++;
    if (doneIdx.size() != 5) begin
      failures++; $display("FAIL fair_count got=%0d want=5", doneIdx.size());
    end else begin
      badGap = 0;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (doneIdx[i] != order[i]) begin
          failures++; $display("FAIL fair_order[%0d] got=%0d want=%0d", i, doneIdx[i], order[i]);
        end
        if (i > 0 && doneCyc[i] - doneCyc[i-1] != 4 + TS) badGap++;
      end
      checks++;
      if (badGap != 0) begin failures++; $display("FAIL fair_spacing bad_gaps=%0d want=0", badGap); end
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      beat_t o, e;
      o = obsQ.pop_front(); e = expQ.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL fair_beat got=%h want=%h", o, e); end
    end
    checks++;
    if (obsQ.size() != 0 || expQ.size() != 0) begin
      failures++; $display("FAIL fair_leftover obs=%0d exp=%0d want=0/0", obsQ.size(), expQ.size());
    end
  endtask

  task automatic test_backpressure();
    int fullLeft = 0;
    bit stalled = 0;
    stallCycles = 0; holdViol = 0; dreadyWhileFull = 0; dreadyNonGrant = 0;
    doneIdx.delete(); doneCyc.delete();
    setMsg(2, 20'hBEEF1, 4);
    req_valid[2] = 1'b1; req_dvalid[2] = 1'b1;
    for (int i = 0; i < 60 && doneIdx.size() == 0; i++) begin
      tick();
      if (fullLeft > 0) begin
        fullLeft--;
        if (fullLeft == 0) gf_full = 1'b0;
      end else if (!stalled && beatCnt[2] == 2) begin
        gf_full = 1'b1;
        fullLeft = 5;
        stalled = 1;
      end
    end
    gf_full = 1'b0;
    repeat (3) tick();
    checks++;
    if (stallCycles != 5) begin failures++; $display("FAIL bp_stall_cycles got=%0d want=5", stallCycles); end
    checks++;
    if (holdViol != 0) begin failures++; $display("FAIL bp_hold violations=%0d want=0", holdViol); end
    checks++;
    if (dreadyWhileFull != 0 || dreadyNonGrant != 0) begin
      failures++; $display("FAIL bp_dready full=%0d nongrant=%0d want=0/0", dreadyWhileFull, dreadyNonGrant);
    end
    checks++;
    if (doneIdx.size() != 1 || doneIdx[0] != 2) begin
      failures++; $display("FAIL bp_done count=%0d want=1 on req 2", doneIdx.size());
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      beat_t o, e;
      o = obsQ.pop_front(); e = expQ.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL bp_beat got=%h want=%h", o, e); end
    end
    checks++;
    if (obsQ.size() != 0 || expQ.size() != 0) begin
      failures++; $display("FAIL bp_leftover obs=%0d exp=%0d want=0/0", obsQ.size(), expQ.size());
    end
  endtask

  task automatic test_zero_len();
    int c0;
    reqCycles = 0;
    doneIdx.delete(); doneCyc.delete();
    setMsg(1, 20'h0ABCD, 0);
    c0 = cyc;
    req_valid[1] = 1'b1; req_dvalid[1] = 1'b1;
    for (int i = 0; i < 20 && doneIdx.size() == 0; i++) tick();
    repeat (3) tick();
    checks++;
    if (doneIdx.size() != 1 || doneIdx[0] != 1) begin
      failures++; $display("FAIL zero_done count=%0d want=1 on req 1", doneIdx.size());
    end else begin
      checks++;
      if (doneCyc[0] - c0 != 2 + TS) begin
        failures++; $display("FAIL zero_done_latency got=%0d want=%0d", doneCyc[0] - c0, 2 + TS);
      end
    end
    checks++;
    if (reqCycles != TS) begin failures++; $display("FAIL zero_beats got=%0d want=%0d", reqCycles, TS); end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      beat_t o, e;
      o = obsQ.pop_front(); e = expQ.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL zero_beat got=%h want=%h", o, e); end
    end
    checks++;
    if (obsQ.size() != 0 || expQ.size() != 0) begin
      failures++; $display("FAIL zero_leftover obs=%0d exp=%0d want=0/0", obsQ.size(), expQ.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [108:0] outs;
    beatsSeen = 0;
    doneIdx.delete(); doneCyc.delete();
    setMsg(0, 20'h77777, 5);
    req_valid[0] = 1'b1; req_dvalid[0] = 1'b1;
    for (int i = 0; i < 30 && beatsSeen < 2 + TS; i++) tick();
    checks++;
    if (beatsSeen != 2 + TS) begin failures++; $display("FAIL mid_pre_beats got=%0d want=%0d", beatsSeen, 2 + TS); end
    #2;
    reset_n = 1'b0;
    req_valid = '0; req_dvalid = '0;
    #1;
    outs = {gf_req, gf_lock, gf_busy, req_done, req_dready, grant_id, gf_cbid, gf_len, gf_data};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL mid_reset_outputs got=%h want=0", outs); end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      beat_t o, e;
      o = obsQ.pop_front(); e = expQ.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL mid_pre_beat got=%h want=%h", o, e); end
    end
    expQ.delete(); obsQ.delete();
    @(posedge fclk); #1 reset_n = 1'b1;
`ifdef GFIFO_ARB_TS_EN
    benchPtr = NREQ - 1;
    lockSeen = 0;
`endif
    setMsg(0, 20'h11111, 1);
    setMsg(1, 20'h22222, 1);
    req_valid[1:0] = 2'b11; req_dvalid[1:0] = 2'b11;
    for (int i = 0; i < 40 && doneIdx.size() < 2; i++) tick();
    repeat (3) tick();
    checks++;
    if (doneIdx.size() != 2 || doneIdx[0] != 0 || doneIdx[1] != 1) begin
      failures++;
      $display("FAIL mid_regrant_order count=%0d first=%0d want=2 starting at 0",
               doneIdx.size(), (doneIdx.size() > 0) ? doneIdx[0] : -1);
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      beat_t o, e;
      o = obsQ.pop_front(); e = expQ.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL mid_beat got=%h want=%h", o, e); end
    end
    checks++;
    if (obsQ.size() != 0 || expQ.size() != 0) begin
      failures++; $display("FAIL mid_leftover obs=%0d exp=%0d want=0/0", obsQ.size(), expQ.size());
    end
  endtask

`ifdef GFIFO_ARB_TS_EN
  task automatic test_ts_header();
    beat_t first;
    beatsSeen = 0;
    doneIdx.delete(); doneCyc.delete();
    sim_time = 64'h1000;
    setMsg(3, 20'h13579, 2);
    req_valid[3] = 1'b1; req_dvalid[3] = 1'b1;
    for (int i = 0; i < 30 && doneIdx.size() == 0; i++) tick();
    repeat (3) tick();
    checks++;
    if (beatsSeen != 3 || obsQ.size() == 0) begin
      failures++; $display("FAIL ts_beats got=%0d want=3", beatsSeen);
    end else begin
      first = obsQ[0];
      checks++;
      if (first.data[63:0] !== 64'h1000 || first.len !== 12'd3) begin
        failures++; $display("FAIL ts_header data=%h len=%0d want=1000/3", first.data, first.len);
      end
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      beat_t o, e;
      o = obsQ.pop_front(); e = expQ.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL ts_beat got=%h want=%h", o, e); end
    end
    checks++;
    if (obsQ.size() != 0 || expQ.size() != 0) begin
      failures++; $display("FAIL ts_leftover obs=%0d exp=%0d want=0/0", obsQ.size(), expQ.size());
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
`ifdef GFIFO_ARB_TS_EN
    test_ts_header();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
